// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM pipeline register.
// Define EXECUTE_MULT_EN to build in the 33-cycle shift-add multiplier and its stall FSM.
module execute_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] readData_1,
    input  logic [31:0] readData_2,
    input  logic [31:0] immediate,
    input  logic [4:0]  rt_FD,
    input  logic [4:0]  rd_FD,
    input  logic [3:0]  aluCtrl,
    input  logic        aluSrc,
    input  logic        regDst,
    input  logic        regWrite_in,
    input  logic        memToReg_in,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic        branch_in,
    input  logic [1:0]  forwardA,
    input  logic [1:0]  forwardB,
    input  logic [31:0] forwardALUResult,
    input  logic [31:0] writeData,
    input  logic        exFlush,
    output logic [31:0] arithmeticOut,
    output logic [31:0] MEMwriteData,
    output logic [4:0]  regWriteSel,
    output logic        negFlag,
    output logic        zeroFlag,
    output logic        regWrite,
    output logic        memToReg,
    output logic        memRead,
    output logic        memWrite,
    output logic        branchCtrl,
    output logic        exBusy
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    logic [31:0] op_a;
    logic [31:0] fwd_b;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic [4:0]  dest_sel;
    logic [4:0]  ctrl_in;

    logic [31:0] result_d, result_q;
    logic [31:0] wdata_d, wdata_q;
    logic [4:0]  sel_d, sel_q;
    logic        neg_d, neg_q;
    logic        zero_d, zero_q;
    logic [4:0]  ctrl_d, ctrl_q;
    logic        load_valid;

    // Codes 0 and 3 both select the register file value.
    always_comb begin
        case (forwardA)
            2'd1:    op_a = forwardALUResult;
            2'd2:    op_a = writeData;
            default: op_a = readData_1;
        endcase
        case (forwardB)
            2'd1:    fwd_b = forwardALUResult;
            2'd2:    fwd_b = writeData;
            default: fwd_b = readData_2;
        endcase
    end

    assign op_b     = aluSrc ? immediate : fwd_b;
    assign dest_sel = regDst ? rd_FD : rt_FD;
    assign ctrl_in  = {regWrite_in, memToReg_in, memRead_in, memWrite_in, branch_in};

    // MUL is not handled here; it yields 0 like the unused codes.
    always_comb begin
        alu_result = '0;
        case (aluCtrl)
            ALU_ADD:  alu_result = op_a + op_b;
            ALU_SUB:  alu_result = op_a - op_b;
            ALU_AND:  alu_result = op_a & op_b;
            ALU_OR:   alu_result = op_a | op_b;
            ALU_XOR:  alu_result = op_a ^ op_b;
            ALU_SLT:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLL:  alu_result = op_a << op_b[4:0];
            ALU_SRL:  alu_result = op_a >> op_b[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_PASS: alu_result = op_b;
            default:  alu_result = '0;
        endcase
    end

`ifdef EXECUTE_MULT_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_d, state_q;
    logic [4:0]  count_d, count_q;
    logic [31:0] acc_d, acc_q;
    logic [31:0] mul_a_d, mul_a_q;
    logic [31:0] mul_b_d, mul_b_q;
    logic [31:0] hold_wdata_d, hold_wdata_q;
    logic [4:0]  hold_sel_d, hold_sel_q;
    logic [4:0]  hold_ctrl_d, hold_ctrl_q;
    logic        busy;

    // Operands and the control bundle are captured once at acceptance so
    // the hazard unit may present anything while the multiply runs.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        acc_d        = acc_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        hold_wdata_d = hold_wdata_q;
        hold_sel_d   = hold_sel_q;
        hold_ctrl_d  = hold_ctrl_q;
        busy         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (aluCtrl == ALU_MUL && !exFlush) begin
                    busy         = 1'b1;
                    state_d      = ST_MULT;
                    count_d      = 5'd0;
                    acc_d        = '0;
                    mul_a_d      = op_a;
                    mul_b_d      = op_b;
                    hold_wdata_d = fwd_b;
                    hold_sel_d   = dest_sel;
                    hold_ctrl_d  = ctrl_in;
                end
            end
            ST_MULT: begin
                busy = 1'b1;
                if (exFlush) begin
                    state_d = ST_IDLE;
                    count_d = 5'd0;
                end else begin
                    acc_d   = acc_q + (mul_b_q[count_q] ? (mul_a_q << count_q) : 32'd0);
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                count_d = 5'd0;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= 5'd0;
            acc_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            hold_wdata_q <= '0;
            hold_sel_q   <= '0;
            hold_ctrl_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            hold_wdata_q <= hold_wdata_d;
            hold_sel_q   <= hold_sel_d;
            hold_ctrl_q  <= hold_ctrl_d;
        end
    end

    assign exBusy = busy & ~reset;

    always_comb begin
        result_d   = '0;
        wdata_d    = '0;
        sel_d      = '0;
        ctrl_d     = '0;
        load_valid = 1'b0;
        if (!exFlush) begin
            if (state_q == ST_DONE) begin
                result_d   = acc_q;
                wdata_d    = hold_wdata_q;
                sel_d      = hold_sel_q;
                ctrl_d     = hold_ctrl_q;
                load_valid = 1'b1;
            end else if (state_q == ST_IDLE && aluCtrl != ALU_MUL) begin
                result_d   = alu_result;
                wdata_d    = fwd_b;
                sel_d      = dest_sel;
                ctrl_d     = ctrl_in;
                load_valid = 1'b1;
            end
        end
        neg_d  = load_valid & result_d[31];
        zero_d = load_valid & (result_d == '0);
    end
`else
    assign exBusy = 1'b0;

    always_comb begin
        result_d   = '0;
        wdata_d    = '0;
        sel_d      = '0;
        ctrl_d     = '0;
        load_valid = 1'b0;
        if (!exFlush) begin
            result_d   = alu_result;
            wdata_d    = fwd_b;
            sel_d      = dest_sel;
            ctrl_d     = ctrl_in;
            load_valid = 1'b1;
        end
        neg_d  = load_valid & result_d[31];
        zero_d = load_valid & (result_d == '0);
    end
`endif

    // Bubbles (flush or stall) clear the flags as well as data and control.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ctrl_q   <= '0;
        end else begin
            result_q <= result_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign arithmeticOut = result_q;
    assign MEMwriteData  = wdata_q;
    assign regWriteSel   = sel_q;
    assign negFlag       = neg_q;
    assign zeroFlag      = zero_q;
    assign regWrite      = ctrl_q[4];
    assign memToReg      = ctrl_q[3];
    assign memRead       = ctrl_q[2];
    assign memWrite      = ctrl_q[1];
    assign branchCtrl    = ctrl_q[0];

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage; the multiplier scenarios run when
// EXECUTE_MULT_EN is defined, otherwise the disabled-MUL behaviour is checked.
module tb_execute_stage;

    logic        clock;
    logic        reset;
    logic [31:0] readData_1, readData_2, immediate;
    logic [4:0]  rt_FD, rd_FD;
    logic [3:0]  aluCtrl;
    logic        aluSrc, regDst;
    logic        regWrite_in, memToReg_in, memRead_in, memWrite_in, branch_in;
    logic [1:0]  forwardA, forwardB;
    logic [31:0] forwardALUResult, writeData;
    logic        exFlush;
    logic [31:0] arithmeticOut, MEMwriteData;
    logic [4:0]  regWriteSel;
    logic        negFlag, zeroFlag;
    logic        regWrite, memToReg, memRead, memWrite, branchCtrl;
    logic        exBusy;

    int tests_run;
    int tests_failed;

    execute_stage dut (
        .clock(clock), .reset(reset),
        .readData_1(readData_1), .readData_2(readData_2), .immediate(immediate),
        .rt_FD(rt_FD), .rd_FD(rd_FD),
        .aluCtrl(aluCtrl), .aluSrc(aluSrc), .regDst(regDst),
        .regWrite_in(regWrite_in), .memToReg_in(memToReg_in), .memRead_in(memRead_in),
        .memWrite_in(memWrite_in), .branch_in(branch_in),
        .forwardA(forwardA), .forwardB(forwardB),
        .forwardALUResult(forwardALUResult), .writeData(writeData),
        .exFlush(exFlush),
        .arithmeticOut(arithmeticOut), .MEMwriteData(MEMwriteData),
        .regWriteSel(regWriteSel), .negFlag(negFlag), .zeroFlag(zeroFlag),
        .regWrite(regWrite), .memToReg(memToReg), .memRead(memRead),
        .memWrite(memWrite), .branchCtrl(branchCtrl),
        .exBusy(exBusy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive_alu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        aluCtrl    = ctrl;
        readData_1 = a;
        readData_2 = b;
        forwardA   = 2'd0;
        forwardB   = 2'd0;
        aluSrc     = 1'b0;
        exFlush    = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (arithmeticOut !== 32'd0 || MEMwriteData !== 32'd0 || regWriteSel !== 5'd0 ||
            regWrite !== 1'b0 || zeroFlag !== 1'b0 || exBusy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: out=%h wd=%h sel=%0d rw=%b z=%b busy=%b expected all 0",
                     arithmeticOut, MEMwriteData, regWriteSel, regWrite, zeroFlag, exBusy);
        end
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_add_overflow();
        drive_alu(4'd0, 32'h7FFF_FFFF, 32'd1);
        next_cycle();
        tests_run++;
        if (arithmeticOut !== 32'h8000_0000 || negFlag !== 1'b1 || zeroFlag !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL add_overflow: out=%h n=%b z=%b expected 80000000 n=1 z=0",
                     arithmeticOut, negFlag, zeroFlag);
        end
    endtask

    task automatic test_sub_zero();
        drive_alu(4'd1, 32'd5, 32'd5);
        regDst = 1'b1;
        rd_FD  = 5'd7;
        rt_FD  = 5'd3;
        next_cycle();
        tests_run++;
        if (arithmeticOut !== 32'd0 || zeroFlag !== 1'b1 || negFlag !== 1'b0 || regWriteSel !== 5'd7) begin
            tests_failed++;
            $display("[TB] FAIL sub_zero: out=%h z=%b n=%b sel=%0d expected 0 z=1 n=0 sel=7",
                     arithmeticOut, zeroFlag, negFlag, regWriteSel);
        end
        regDst = 1'b0;
        next_cycle();
        tests_run++;
        if (regWriteSel !== 5'd3) begin
            tests_failed++;
            $display("[TB] FAIL dest_rt: sel=%0d expected 3", regWriteSel);
        end
    endtask

    task automatic test_forwarding();
        drive_alu(4'd0, 32'hAAAA_0000, 32'hBBBB_0000);
        forwardA         = 2'd1;
        forwardALUResult = 32'h10;
        forwardB         = 2'd2;
        writeData        = 32'h3;
        next_cycle();
        tests_run++;
        if (arithmeticOut !== 32'h13 || MEMwriteData !== 32'h3) begin
            tests_failed++;
            $display("[TB] FAIL fwd_regs: out=%h wd=%h expected 13 / 3", arithmeticOut, MEMwriteData);
        end
        aluSrc    = 1'b1;
        immediate = 32'h100;
        next_cycle();
        tests_run++;
        if (arithmeticOut !== 32'h110 || MEMwriteData !== 32'h3) begin
            tests_failed++;
            $display("[TB] FAIL fwd_imm: out=%h wd=%h expected 110 / 3", arithmeticOut, MEMwriteData);
        end
        aluSrc   = 1'b0;
        forwardA = 2'd3;
        forwardB = 2'd0;
        readData_1 = 32'd20;
        readData_2 = 32'd22;
        next_cycle();
        tests_run++;
        if (arithmeticOut !== 32'd42 || MEMwriteData !== 32'd22) begin
            tests_failed++;
            $display("[TB] FAIL fwd_code3: out=%h wd=%h expected 2a / 16", arithmeticOut, MEMwriteData);
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  v_op  [0:11];
        logic [31:0] v_a   [0:11];
        logic [31:0] v_b   [0:11];
        logic [31:0] v_exp [0:11];
        v_op  = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd8, 4'd10, 4'd12, 4'd1};
        v_a   = '{32'hF0F0_F0F0, 32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'd5, 32'd1,
                  32'd1, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd5, 32'd0};
        v_b   = '{32'h0FF0_0FF0, 32'h0000_000F, 32'h0F0F_0F0F, 32'd1, 32'hFFFF_FFFE, 32'd31,
                  32'h21, 32'd4, 32'd4, 32'hDEAD_BEEF, 32'd6, 32'd1};
        v_exp = '{32'h00F0_00F0, 32'hF000_000F, 32'hF0F0_0F0F, 32'd1, 32'd0, 32'h8000_0000,
                  32'd2, 32'h0800_0000, 32'hF800_0000, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF};
        for (int i = 0; i < 12; i++) begin
            drive_alu(v_op[i], v_a[i], v_b[i]);
            next_cycle();
            tests_run++;
            if (arithmeticOut !== v_exp[i] || zeroFlag !== (v_exp[i] == 32'd0) || negFlag !== v_exp[i][31]) begin
                tests_failed++;
                $display("[TB] FAIL alu_op%0d_vec%0d: out=%h z=%b n=%b expected %h", v_op[i], i,
                         arithmeticOut, zeroFlag, negFlag, v_exp[i]);
            end
        end
    endtask

    task automatic test_control_and_flush();
        drive_alu(4'd0, 32'd1, 32'd2);
        regWrite_in = 1'b1; memToReg_in = 1'b1; memRead_in = 1'b1; memWrite_in = 1'b1; branch_in = 1'b1;
        next_cycle();
        tests_run++;
        if ({regWrite, memToReg, memRead, memWrite, branchCtrl} !== 5'b11111 || arithmeticOut !== 32'd3) begin
            tests_failed++;
            $display("[TB] FAIL ctrl_pass: ctrl=%b out=%h expected 11111 / 3",
                     {regWrite, memToReg, memRead, memWrite, branchCtrl}, arithmeticOut);
        end
        exFlush = 1'b1;
        next_cycle();
        tests_run++;
        if ({regWrite, memToReg, memRead, memWrite, branchCtrl} !== 5'b00000 || arithmeticOut !== 32'd0 ||
            MEMwriteData !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL flush_bubble: ctrl=%b out=%h wd=%h expected all 0",
                     {regWrite, memToReg, memRead, memWrite, branchCtrl}, arithmeticOut, MEMwriteData);
        end
        exFlush = 1'b0;
        memToReg_in = 1'b0; memRead_in = 1'b0; memWrite_in = 1'b0; branch_in = 1'b0;
    endtask

    task automatic test_async_reset();
        drive_alu(4'd0, 32'h7FFF_FFFF, 32'd1);
        regWrite_in = 1'b1;
        next_cycle();
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (arithmeticOut !== 32'd0 || regWrite !== 1'b0 || negFlag !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: out=%h rw=%b n=%b expected 0", arithmeticOut, regWrite, negFlag);
        end
        #1;
        reset = 1'b0;
    endtask

`ifdef EXECUTE_MULT_EN
    task automatic test_mul();
        int busy_cycles;
        int bubble_errs;
        busy_cycles = 0;
        bubble_errs = 0;
        drive_alu(4'd9, 32'h12345, 32'd0);
        aluSrc = 1'b1; immediate = 32'h10; regDst = 1'b1; rd_FD = 5'd9; regWrite_in = 1'b1;
        #1;
        if (exBusy === 1'b1) busy_cycles++;
        for (int c = 1; c <= 32; c++) begin
            next_cycle();
            if (exBusy === 1'b1) busy_cycles++;
            if (arithmeticOut !== 32'd0 || regWrite !== 1'b0) bubble_errs++;
            if (c == 5) begin
                readData_1 = 32'hFFFF_FFFF; immediate = 32'h3; regWrite_in = 1'b0; rd_FD = 5'd1;
            end
        end
        next_cycle();
        tests_run++;
        if (busy_cycles != 33 || exBusy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mul_busy: busy cycles=%0d busy in done=%b expected 33 / 0", busy_cycles, exBusy);
        end
        tests_run++;
        if (bubble_errs != 0) begin
            tests_failed++;
            $display("[TB] FAIL mul_bubbles: %0d non-bubble cycles expected 0", bubble_errs);
        end
        next_cycle();
        tests_run++;
        if (arithmeticOut !== 32'h123450 || regWrite !== 1'b1 || regWriteSel !== 5'd9 || zeroFlag !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mul_result: out=%h rw=%b sel=%0d z=%b expected 123450 rw=1 sel=9 z=0",
                     arithmeticOut, regWrite, regWriteSel, zeroFlag);
        end
        drive_alu(4'd0, 32'd0, 32'd0);
        regWrite_in = 1'b0; regDst = 1'b0;
    endtask

    task automatic test_mul_flush();
        int bad;
        bad = 0;
        drive_alu(4'd9, 32'd6, 32'd7);
        regWrite_in = 1'b1;
        for (int c = 0; c < 10; c++) next_cycle();
        exFlush = 1'b1;
        #1;
        tests_run++;
        if (exBusy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mul_flush_busy_hold: busy=%b expected 1", exBusy);
        end
        next_cycle();
        tests_run++;
        if (exBusy !== 1'b0 || arithmeticOut !== 32'd0 || regWrite !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mul_flush_abort: busy=%b out=%h rw=%b expected 0/0/0", exBusy, arithmeticOut, regWrite);
        end
        drive_alu(4'd0, 32'd0, 32'd0);
        regWrite_in = 1'b0;
        for (int c = 0; c < 30; c++) begin
            next_cycle();
            if (arithmeticOut === 32'd42 || exBusy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL mul_flush_no_result: %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_mul_reset();
        int bad;
        bad = 0;
        drive_alu(4'd9, 32'd3, 32'd5);
        regWrite_in = 1'b1;
        for (int c = 0; c < 20; c++) next_cycle();
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (exBusy !== 1'b0 || arithmeticOut !== 32'd0 || regWrite !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mul_reset: busy=%b out=%h rw=%b expected 0", exBusy, arithmeticOut, regWrite);
        end
        drive_alu(4'd0, 32'd2, 32'd2);
        #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if (exBusy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mul_reset_idle: busy=%b expected 0", exBusy);
        end
        next_cycle();
        tests_run++;
        if (arithmeticOut !== 32'd4 || regWrite !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_add: out=%h rw=%b expected 4 / 1", arithmeticOut, regWrite);
        end
        for (int c = 0; c < 15; c++) begin
            next_cycle();
            if (arithmeticOut === 32'd15) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL mul_reset_discard: %0d stale products expected 0", bad);
        end
        regWrite_in = 1'b0;
    endtask

    task automatic test_mul_flush_start();
        drive_alu(4'd9, 32'd3, 32'd4);
        regWrite_in = 1'b1;
        exFlush = 1'b1;
        #1;
        tests_run++;
        if (exBusy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_start_busy: busy=%b expected 0", exBusy);
        end
        next_cycle();
        tests_run++;
        if (arithmeticOut !== 32'd0 || regWrite !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_start_bubble: out=%h rw=%b expected 0 / 0", arithmeticOut, regWrite);
        end
        drive_alu(4'd0, 32'd1, 32'd1);
        next_cycle();
        tests_run++;
        if (arithmeticOut !== 32'd2 || exBusy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_start_idle: out=%h busy=%b expected 2 / 0", arithmeticOut, exBusy);
        end
        regWrite_in = 1'b0;
    endtask
`else
    task automatic test_mul_disabled();
        drive_alu(4'd9, 32'd3, 32'd4);
        regWrite_in = 1'b1;
        #1;
        tests_run++;
        if (exBusy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL nomul_busy: busy=%b expected 0", exBusy);
        end
        next_cycle();
        tests_run++;
        if (arithmeticOut !== 32'd0 || regWrite !== 1'b1 || zeroFlag !== 1'b1 || exBusy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL nomul_result: out=%h rw=%b z=%b busy=%b expected 0 rw=1 z=1 busy=0",
                     arithmeticOut, regWrite, zeroFlag, exBusy);
        end
        regWrite_in = 1'b0;
    endtask
`endif

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        readData_1 = '0; readData_2 = '0; immediate = '0;
        rt_FD = '0; rd_FD = '0; aluCtrl = '0; aluSrc = 1'b0; regDst = 1'b0;
        regWrite_in = 1'b0; memToReg_in = 1'b0; memRead_in = 1'b0; memWrite_in = 1'b0; branch_in = 1'b0;
        forwardA = '0; forwardB = '0; forwardALUResult = '0; writeData = '0; exFlush = 1'b0;

        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_forwarding();
        test_alu_ops();
        test_control_and_flush();
        test_async_reset();
`ifdef EXECUTE_MULT_EN
        test_mul();
        test_mul_flush();
        test_mul_reset();
        test_mul_flush_start();
`else
        test_mul_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have ports: readData_1, readData_2, immediate  in  32 each  ID/EX operands from decode.
REQ-004 SHALL have ports: rt_FD, rd_FD  in  5 each  destination candidates.
REQ-005 SHALL have ports: aluCtrl  in  4  operation select; aluSrc  in  1  B = immediate; regDst  in  1  dest = rd.
REQ-006 SHALL have ports: regWrite_in, memToReg_in, memRead_in, memWrite_in, branch_in  in  1 each  control bundle.
REQ-007 SHALL have ports: forwardA, forwardB  in  2 each  operand source: 0 register, 1 forwardALUResult, 2 writeData, 3 register.
REQ-008 SHALL have ports: forwardALUResult, writeData  in  32 each  EX/MEM and MEM/WB bypass values.
REQ-009 SHALL have ports: exFlush  in  1  squash current instruction.
REQ-010 SHALL have ports: arithmeticOut, MEMwriteData  out  32 each  registered ALU result and store data.
REQ-011 SHALL have ports: regWriteSel  out  5; negFlag, zeroFlag  out  1; regWrite, memToReg, memRead, memWrite, branchCtrl  out  1 each; all EX/MEM registered.
REQ-012 SHALL have ports: exBusy  out  1  combinational stall request to hazard unit.

Function
REQ-013 Operand A SHALL be forwardA-selected; operand B SHALL be immediate when aluSrc=1, else forwardB-selected value.
REQ-014 MEMwriteData SHALL capture the forwardB-selected value, never the immediate.
REQ-015 regWriteSel SHALL capture rd_FD when regDst=1, else rt_FD.
REQ-016 aluCtrl: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT signed (result 1/0), 6 SLL, 7 SRL, 8 SRA (shift by B[4:0]), 9 MUL, 10 PASS B, 11-15 result 0; add/sub wrap modulo 2^32.
REQ-017 negFlag SHALL capture result bit 31; zeroFlag SHALL capture (result==0); both from the same result as arithmeticOut.
REQ-018 Non-MUL ops: single cycle; EX/MEM registers load on every rising edge where exBusy=0.
REQ-019 MUL FSM states IDLE, MULT, DONE; IDLE->MULT when aluCtrl=9 and exFlush=0; MULT iterates shift-add one bit per cycle, 5-bit counter 0..31; MULT->DONE at count 31; DONE->IDLE unconditionally.
REQ-020 exBusy SHALL be 1 in IDLE with a MUL accepted, and throughout MULT; 0 in DONE: 33 busy cycles total.
REQ-021 While exBusy=1 EX/MEM SHALL load a bubble (all control outputs 0, data 0); upstream holds inputs stable.
REQ-022 In DONE, EX/MEM SHALL load low 32 bits of A*B with the held control bundle.
REQ-023 MUL operands SHALL be latched on IDLE->MULT; input changes during MULT are ignored.
REQ-024 exFlush=1 SHALL load a bubble into EX/MEM; during MULT or DONE it SHALL abort to IDLE with no result written.
REQ-025 exFlush and MUL start in same cycle: flush wins, FSM stays IDLE, exBusy=0.

Reset
REQ-026 On reset all EX/MEM outputs SHALL be 0, FSM IDLE, counter 0, exBusy 0, immediately and asynchronously.
REQ-027 Reset during MULT SHALL discard the partial product; first post-reset instruction executes normally.

Configuration
REQ-028 Macro EXECUTE_MULT_EN defined: MUL path and FSM per REQ-019..REQ-025 compiled in.
REQ-029 Macro EXECUTE_MULT_EN undefined: no FSM or multiplier; aluCtrl=9 yields result 0 with control passed through; exBusy tied 0.

Verification
REQ-030 ADD A=0x7FFFFFFF B=1 -> next edge arithmeticOut=0x80000000, negFlag=1, zeroFlag=0.
REQ-031 SUB A=5 B=5, regDst=1, rd=7 -> arithmeticOut=0, zeroFlag=1, regWriteSel=7.
REQ-032 forwardA=1 forwardALUResult=0x10, forwardB=2 writeData=0x3, aluCtrl=0 -> arithmeticOut=0x13; aluSrc=1 immediate=0x100, forwardB=2 -> arithmeticOut=0x110, MEMwriteData=0x3.
REQ-033 MULT_EN: MUL A=0x12345 B=0x10 -> exBusy high 33 cycles, bubbles meanwhile, then arithmeticOut=0x123450 with regWrite=1.
REQ-034 MUL started, exFlush at cycle 10 -> exBusy drops next cycle, bubble output, no product written; reset at cycle 20 of a second MUL -> all outputs 0, FSM IDLE.
REQ-035 Without MULT_EN: aluCtrl=9 A=3 B=4 -> exBusy stays 0, arithmeticOut=0 next edge.
